// File: rtl/prog_rom_ctrl_pkg.sv
// prog_rom_ctrl_pkg: shared types and constants for the uCOM-43 program ROM controller
package prog_rom_ctrl_pkg;
    typedef enum logic [1:0] {HOLD, RUN, LOAD} state_t;
    localparam logic [1:0] PHASE_DBG = 2'd0;
    localparam logic [1:0] PHASE_CE  = 2'd3;
    localparam int ROM_DEPTH = 2048;
endpackage

// File: rtl/prog_rom_ctrl_if.sv
// prog_rom_ctrl_if: host download and debug read bus of the program ROM controller
interface prog_rom_ctrl_if #(parameter int ADDR_W = 11, parameter int DATA_W = 8);
    logic              dl_start;
    logic              dl_valid;
    logic [DATA_W-1:0] dl_data;
    logic              dl_ready;
    logic              dl_end;
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_data;
    modport master (
        output dl_start, dl_valid, dl_data, dl_end, dbg_req, dbg_addr,
        input  dl_ready, dbg_ack, dbg_data
    );
    modport slave (
        input  dl_start, dl_valid, dl_data, dl_end, dbg_req, dbg_addr,
        output dl_ready, dbg_ack, dbg_data
    );
endinterface

// File: rtl/prog_rom_ctrl_rom.sv
// prog_rom: single-port program memory with write enable and registered read
module prog_rom
    import prog_rom_ctrl_pkg::*;
#(
    parameter int ADDR_W = $clog2(ROM_DEPTH),
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/prog_rom_ctrl.sv
// prog_rom_ctrl: schedules fetch, download and debug accesses to the program ROM
// and generates the core's 1-in-4 clock enable and reset.
module prog_rom_ctrl
    import prog_rom_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 8,
    parameter int RST_HOLD = 8
) (
    input  logic              clk,
    input  logic              _reset,
    prog_rom_ctrl_if.slave    bus,
    input  logic [ADDR_W-1:0] mcu_pc,
    output logic [DATA_W-1:0] mcu_rdat,
    output logic              mcu_ce,
    output logic              mcu_reset,
    output logic              loaded,
    output logic [ADDR_W:0]   dl_count,
    output logic [DATA_W-1:0] dl_sum,
    output logic              dl_ovf
);
    localparam int HW = $clog2(RST_HOLD + 1);
    state_t            state, state_nx;
    logic [HW-1:0]     hold_cnt, hold_nx;
    logic [1:0]        phase;
    logic              run, load, dbg_rd, xfer, we, fetch_q, ack_q;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rdata, mcu_hold, dbg_hold;

    assign run       = state == RUN;
    assign load      = state == LOAD;
    assign xfer      = load & bus.dl_valid;
    assign we        = xfer & ~bus.dl_start & ~dl_count[ADDR_W];
    assign dbg_rd    = run & (phase == PHASE_DBG) & bus.dbg_req & ~bus.dl_start;
    // While loading, the byte count doubles as the write address.
    assign rom_addr  = load ? dl_count[ADDR_W-1:0] : dbg_rd ? bus.dbg_addr : mcu_pc;
    assign mcu_ce    = run & (phase == PHASE_CE);
    assign mcu_reset = ~run;
    assign bus.dl_ready = load;
    assign bus.dbg_ack  = ack_q;
    // The shared read register is steered to whichever consumer issued the read; the other holds.
    assign mcu_rdat     = fetch_q ? rdata : mcu_hold;
    assign bus.dbg_data = ack_q ? rdata : dbg_hold;

    prog_rom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rom (
        .clk   (clk),
        .we    (we),
        .addr  (rom_addr),
        .wdata (bus.dl_data),
        .rdata (rdata)
    );

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        if (bus.dl_start) begin
            state_nx = LOAD;
        end else if (state == HOLD) begin
            state_nx = hold_cnt <= HW'(1) ? RUN : HOLD;
            hold_nx  = hold_cnt - HW'(1);
        end else if (load & bus.dl_end) begin
            state_nx = HOLD;
            hold_nx  = HW'(RST_HOLD);
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state    <= HOLD;
            hold_cnt <= HW'(RST_HOLD);
            phase    <= 2'd0;
            fetch_q  <= 1'b0;
            ack_q    <= 1'b0;
            mcu_hold <= '0;
            dbg_hold <= '0;
            loaded   <= 1'b0;
            dl_count <= '0;
            dl_sum   <= '0;
            dl_ovf   <= 1'b0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_nx;
            phase    <= run & ~bus.dl_start ? phase + 2'd1 : 2'd0;
            fetch_q  <= run & ~dbg_rd;
            ack_q    <= dbg_rd;
            mcu_hold <= mcu_rdat;
            dbg_hold <= bus.dbg_data;
            if (bus.dl_start) begin
                dl_count <= '0;
                dl_sum   <= '0;
                dl_ovf   <= 1'b0;
            end else begin
                if (we) begin
                    dl_count <= dl_count + (ADDR_W+1)'(1);
                    dl_sum   <= dl_sum + bus.dl_data;
                end
                if (xfer & dl_count[ADDR_W]) dl_ovf <= 1'b1;
            end
            if (load & bus.dl_end & ~bus.dl_start) loaded <= 1'b1;
        end
    end
endmodule

// File: tb/tb_prog_rom_ctrl.sv
// tb_prog_rom_ctrl: directed self-checking bench for prog_rom_ctrl
module tb_prog_rom_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [10:0] mcu_pc = '0;
    logic [7:0]  mcu_rdat;
    logic        mcu_ce, mcu_reset, loaded, dl_ovf;
    logic [11:0] dl_count;
    logic [7:0]  dl_sum;
    int          checks = 0;
    int          errors = 0;

    prog_rom_ctrl_if bus ();

    prog_rom_ctrl dut (
        .clk       (clk),
        ._reset    (rst_n),
        .bus       (bus.slave),
        .mcu_pc    (mcu_pc),
        .mcu_rdat  (mcu_rdat),
        .mcu_ce    (mcu_ce),
        .mcu_reset (mcu_reset),
        .loaded    (loaded),
        .dl_count  (dl_count),
        .dl_sum    (dl_sum),
        .dl_ovf    (dl_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat(input int a);
        logic [10:0] x;
        x = 11'(a);
        return a == 'h123 ? 8'hA5 : a == 'h7FF ? 8'h3C : x[7:0] ^ 8'h5A;
    endfunction

    task automatic wait_run(input string tag, input int exp);
        int n = 0;
        while (mcu_reset && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'(exp));
    endtask

    task automatic fetch(input string tag, input logic [10:0] a, input logic [7:0] exp);
        int n = 0;
        mcu_pc = a;
        tick();
        while (!mcu_ce && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_ce"}, 32'(mcu_ce), 32'(1));
        check(tag, 32'(mcu_rdat), 32'(exp));
    endtask

    task automatic dbg_read(input string tag, input logic [10:0] a, input logic [7:0] exp);
        int n = 0;
        bus.dbg_addr = a;
        bus.dbg_req  = 1'b1;
        while (!bus.dbg_ack && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_ack"}, 32'(bus.dbg_ack), 32'(1));
        check(tag, 32'(bus.dbg_data), 32'(exp));
        bus.dbg_req = 1'b0;
        tick();
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        bus.dl_valid = 1'b1;
        bus.dl_data  = d;
        bus.dl_end   = last;
        tick();
        bus.dl_valid = 1'b0;
        bus.dl_end   = 1'b0;
    endtask

    task automatic start();
        bus.dl_start = 1'b1;
        tick();
        bus.dl_start = 1'b0;
    endtask

    initial begin
        logic [7:0] sum = '0;
        bus.dl_start = 1'b0;
        bus.dl_valid = 1'b0;
        bus.dl_data  = '0;
        bus.dl_end   = 1'b0;
        bus.dbg_req  = 1'b0;
        bus.dbg_addr = '0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_mcu_reset", 32'(mcu_reset), 32'(1));
        check("rst_ce", 32'(mcu_ce), 32'(0));
        check("rst_ready", 32'(bus.dl_ready), 32'(0));
        check("rst_ack", 32'(bus.dbg_ack), 32'(0));
        check("rst_dbg_data", 32'(bus.dbg_data), 32'(0));
        check("rst_rdat", 32'(mcu_rdat), 32'(0));
        check("rst_loaded", 32'(loaded), 32'(0));
        check("rst_count", 32'(dl_count), 32'(0));
        check("rst_sum", 32'(dl_sum), 32'(0));
        check("rst_ovf", 32'(dl_ovf), 32'(0));
        tick();
        tick();
        rst_n = 1'b1;
        wait_run("rst_hold", 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ce_phase%0d", i), 32'(mcu_ce), 32'(i % 4 == 3));
            tick();
        end

        // Fill the whole ROM, then offer one byte too many.
        start();
        check("load_ready", 32'(bus.dl_ready), 32'(1));
        check("load_reset", 32'(mcu_reset), 32'(1));
        for (int i = 0; i <= 2048; i++) begin
            if (i == 2048) begin
                check("full_ovf_before", 32'(dl_ovf), 32'(0));
                send(8'hEE, 1'b0);
            end else begin
                sum += pat(i);
                send(pat(i), 1'b0);
            end
        end
        check("ovf_count", 32'(dl_count), 32'(2048));
        check("ovf_flag", 32'(dl_ovf), 32'(1));
        check("ovf_sum", 32'(dl_sum), 32'(sum));
        bus.dl_end = 1'b1;
        tick();
        bus.dl_end = 1'b0;
        check("end_loaded", 32'(loaded), 32'(1));
        check("end_ready", 32'(bus.dl_ready), 32'(0));
        wait_run("end_hold", 8);

        check("run_phase0_ce", 32'(mcu_ce), 32'(0));
        mcu_pc = 11'h123;
        tick();
        tick();
        tick();
        check("fetch_ce", 32'(mcu_ce), 32'(1));
        check("fetch_123", 32'(mcu_rdat), 32'(8'hA5));
        bus.dbg_addr = 11'h7FF;
        bus.dbg_req  = 1'b1;
        tick();
        check("dbg_no_early_ack", 32'(bus.dbg_ack), 32'(0));
        tick();
        check("dbg_ack_phase1", 32'(bus.dbg_ack), 32'(1));
        check("dbg_data_7ff", 32'(bus.dbg_data), 32'(8'h3C));
        check("dbg_rdat_hold", 32'(mcu_rdat), 32'(8'hA5));
        bus.dbg_req = 1'b0;
        tick();
        check("dbg_ack_pulse", 32'(bus.dbg_ack), 32'(0));
        check("dbg_data_held", 32'(bus.dbg_data), 32'(8'h3C));
        tick();
        check("dbg_next_ce", 32'(mcu_ce), 32'(1));
        check("dbg_next_rdat", 32'(mcu_rdat), 32'(8'hA5));
        fetch("fetch_0", 11'h000, 8'h5A);
        fetch("fetch_7ff", 11'h7FF, 8'h3C);

        bus.dl_end = 1'b1;
        tick();
        bus.dl_end = 1'b0;
        check("stray_end_reset", 32'(mcu_reset), 32'(0));

        // Restart mid-load, then a short download ending with a same-cycle transfer.
        start();
        send(8'h77, 1'b0);
        send(8'h88, 1'b0);
        check("pre_restart_count", 32'(dl_count), 32'(2));
        start();
        check("restart_count", 32'(dl_count), 32'(0));
        check("restart_sum", 32'(dl_sum), 32'(0));
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'hFF, 1'b1);
        check("small_count", 32'(dl_count), 32'(3));
        check("small_sum", 32'(dl_sum), 32'(8'h02));
        check("small_ovf", 32'(dl_ovf), 32'(0));
        check("small_loaded", 32'(loaded), 32'(1));
        wait_run("small_hold", 8);
        fetch("small_fetch2", 11'h002, 8'hFF);
        dbg_read("small_dbg0", 11'h000, 8'h01);
        dbg_read("small_dbg1", 11'h001, 8'h02);
        dbg_read("small_dbg3", 11'h003, pat(3));

        // Abort a download with reset; the written prefix survives.
        start();
        send(8'h99, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_loaded", 32'(loaded), 32'(0));
        check("abort_reset", 32'(mcu_reset), 32'(1));
        check("abort_ready", 32'(bus.dl_ready), 32'(0));
        check("abort_count", 32'(dl_count), 32'(0));
        tick();
        rst_n = 1'b1;
        wait_run("abort_hold", 8);
        dbg_read("abort_dbg0", 11'h000, 8'h99);
        dbg_read("abort_dbg1", 11'h001, 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end
endmodule
